// File: rtl/grid_streamer.sv
// Grid byte stream to per-column en/split_in strobes for the splitter, followed by
// a drain phase that accumulates the splitter's count over one row's worth of pulses.
module grid_streamer #(
  parameter int LINE_LENGTH = 141,
  parameter int CNT_W       = 64,
  parameter int SUM_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  input  logic             eof,
  output logic             char_ready,
  output logic             en,
  output logic             split_in,
  input  logic [CNT_W-1:0] count_in,
  output logic [SUM_W-1:0] sum_out,
  output logic             done,
  output logic             err,
  output logic             sum_ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(LINE_LENGTH + 1);
  localparam int DW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_NL    = 8'h0A;

  typedef enum logic [1:0] {
    ST_FEED  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             split_q, split_d;
  logic [CW-1:0]    col_q, col_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             lead_q, lead_d;
  logic             accept;
  logic             last_drain;
  logic [SUM_W:0]   acc;

  // Handshake: a byte transfers on a rising edge where char_valid && char_ready.
  assign accept     = char_valid && (state_q == ST_FEED);
  assign last_drain = (dcnt_q == DW'(LINE_LENGTH - 1)) && !lead_q;
  assign acc        = {1'b0, sum_q} + (SUM_W + 1)'(count_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FEED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FEED:  if (eof) state_d = ST_DRAIN;
      ST_DRAIN: if (last_drain) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_comb begin
    en_d    = 1'b0;
    split_d = 1'b0;
    col_d   = col_q;
    dcnt_d  = dcnt_q;
    sum_d   = sum_q;
    done_d  = done_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    lead_d  = lead_q;
    case (state_q)
      ST_FEED: begin
        if (accept) begin
          if (char_in == CH_NL) begin
            col_d = '0;
          end else begin
            en_d    = 1'b1;
            split_d = (char_in == CH_CARET);
            if (col_q == CW'(LINE_LENGTH)) err_d = 1'b1;
            else                           col_d = col_q + 1'b1;
          end
        end
        if (eof) begin
          // A byte accepted alongside eof gets its own strobe before the drain pulses.
          en_d   = 1'b1;
          dcnt_d = '0;
          lead_d = accept && (char_in != CH_NL);
        end
      end
      ST_DRAIN: begin
        if (lead_q) begin
          lead_d = 1'b0;
          en_d   = 1'b1;
        end else begin
          sum_d = acc[SUM_W-1:0];
          if (acc[SUM_W]) ovf_d = 1'b1;
          if (last_drain) begin
            done_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
            en_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      split_q <= 1'b0;
      col_q   <= '0;
      dcnt_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      lead_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      split_q <= split_d;
      col_q   <= col_d;
      dcnt_q  <= dcnt_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      lead_q  <= lead_d;
    end
  end

  always_comb begin
    char_ready = (state_q == ST_FEED);
    en         = en_q;
    split_in   = split_q;
    sum_out    = sum_q;
    done       = done_q;
    err        = err_q;
    sum_ovf    = ovf_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_grid_streamer.sv
// Directed bench for grid_streamer with a 3-column grid and an 8-bit accumulator.
module tb_grid_streamer;

  localparam int LL    = 3;
  localparam int CNT_W = 8;
  localparam int SUM_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       char_in = 8'h00;
  logic             char_valid = 1'b0;
  logic             eof = 1'b0;
  logic             char_ready;
  logic             en;
  logic             split_in;
  logic [CNT_W-1:0] count_in = '0;
  logic [SUM_W-1:0] sum_out;
  logic             done;
  logic             err;
  logic             sum_ovf;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  grid_streamer #(.LINE_LENGTH(LL), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .eof(eof), .char_ready(char_ready), .en(en), .split_in(split_in),
    .count_in(count_in), .sum_out(sum_out), .done(done), .err(err),
    .sum_ovf(sum_ovf), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic step(input logic [7:0] c, input logic v, input logic e);
    char_in = c; char_valid = v; eof = e;
    @(posedge clock); #1;
    char_valid = 1'b0; eof = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Drain with given counts; counts are presented while en is high, one per edge.
  task automatic drain(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    logic [7:0] cs [3];
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_en%0d", i), en, 1);
      check($sformatf("drain_rdy%0d", i), char_ready, 0);
      count_in = cs[i];
      step(8'h00, 1'b1, 1'b1);
    end
    count_in = '0;
    check("drain_en_off", en, 0);
  endtask

  initial begin
    logic [7:0] row [4];
    logic       exp_en [4];
    logic       exp_sp [4];
    row[0] = 8'h2E; row[1] = 8'h5E; row[2] = 8'h2E; row[3] = 8'h0A;
    exp_en[0] = 1; exp_en[1] = 1; exp_en[2] = 1; exp_en[3] = 0;
    exp_sp[0] = 0; exp_sp[1] = 1; exp_sp[2] = 0; exp_sp[3] = 0;

    #2;
    check("rst_en", en, 0);
    check("rst_split", split_in, 0);
    check("rst_sum", sum_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", sum_ovf, 0);
    check("rst_ready", char_ready, 1);
    do_reset();

    // ".^.\n" back-to-back
    for (int i = 0; i < 4; i++) begin
      step(row[i], 1'b1, 1'b0);
      check($sformatf("row_en%0d", i), en, exp_en[i]);
      check($sformatf("row_split%0d", i), split_in, exp_sp[i]);
    end
    check("row_err", err, 0);

    // two-cycle valid gap mid-row
    step(8'h2E, 1'b1, 1'b0);
    check("gap_first_en", en, 1);
    step(8'h5E, 1'b0, 1'b0);
    check("gap_en0", en, 0);
    step(8'h5E, 1'b0, 1'b0);
    check("gap_en1", en, 0);
    step(8'h5E, 1'b1, 1'b0);
    check("resume_en", en, 1);
    check("resume_split", split_in, 1);
    step(8'h0D, 1'b1, 1'b0);
    check("cr_en", en, 1);
    check("cr_split", split_in, 0);
    check("gap_err", err, 0);
    step(8'h0A, 1'b1, 1'b0);
    check("gap_nl_en", en, 0);

    // drain 5,7,9 -> 21, then hold
    drain(8'd5, 8'd7, 8'd9);
    check("drain_sum", sum_out, 21);
    check("drain_done", done, 1);
    check("drain_ovf", sum_ovf, 0);
    for (int i = 0; i < 10; i++) begin
      count_in = 8'($urandom_range(255, 1));
      step(8'h5E, 1'b1, 1'b1);
    end
    check("hold_sum", sum_out, 21);
    check("hold_done", done, 1);
    check("hold_en", en, 0);
    check("hold_ready", char_ready, 0);

    // overlong row
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h5E, 1'b1, 1'b0);
      check($sformatf("long_en%0d", i), en, 1);
      check($sformatf("long_split%0d", i), split_in, 1);
      check($sformatf("long_err%0d", i), err, (i == 3) ? 1 : 0);
    end
    drain(8'd1, 8'd1, 8'd1);
    check("long_err_drain", err, 1);
    check("long_sum", sum_out, 3);

    // accumulator wrap
    do_reset();
    drain(8'd200, 8'd100, 8'd0);
    check("ovf_sum", sum_out, 44);
    check("ovf_flag", sum_ovf, 1);
    check("ovf_done", done, 1);

    // reset during the 2nd drain cycle, then a clean rerun
    do_reset();
    step(8'h00, 1'b0, 1'b1);
    count_in = 8'd4;
    step(8'h00, 1'b0, 1'b0);
    check("mid_sum_pre", sum_out, 4);
    reset = 1'b1;
    #1;
    check("mid_en", en, 0);
    check("mid_sum", sum_out, 0);
    check("mid_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    count_in = '0;
    check("mid_ready", char_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step(row[i], 1'b1, 1'b0);
      check($sformatf("rerun_en%0d", i), en, exp_en[i]);
      check($sformatf("rerun_split%0d", i), split_in, exp_sp[i]);
    end
    drain(8'd10, 8'd20, 8'd30);
    check("rerun_sum", sum_out, 60);
    check("rerun_done", done, 1);
    check("rerun_ovf", sum_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
